// File: rtl/ball_loop_sequencer.sv
// One-hot program-location controller for the X/Y/Z/A/B compare-and-update loop.
// A single shared unsigned less-than unit is time-multiplexed across the compare states.
module ball_loop_sequencer #(
  parameter int W        = 8,
  parameter int MAX_ITER = 255,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x_in,
  input  logic [W-1:0]  y_in,
  input  logic [W-1:0]  z_in,
  input  logic [W-1:0]  b_in,
  output logic          busy,
  output logic          done,
  output logic          ok,
  output logic          timeout,
  output logic          bad,
  output logic          onehot_err,
  output logic [W-1:0]  a_out,
  output logic [W-1:0]  z_out,
  output logic [CW-1:0] iter_cnt,
  output logic          prop
);

  localparam logic [8:0] S_IDLE    = 9'b0_0000_0001;
  localparam logic [8:0] S_CMP_XY  = 9'b0_0000_0010;
  localparam logic [8:0] S_LOAD_A  = 9'b0_0000_0100;
  localparam logic [8:0] S_CMP_AB  = 9'b0_0000_1000;
  localparam logic [8:0] S_UPD     = 9'b0_0001_0000;
  localparam logic [8:0] S_CMP_XZ  = 9'b0_0010_0000;
  localparam logic [8:0] S_DONE_OK = 9'b0_0100_0000;
  localparam logic [8:0] S_ABORT   = 9'b0_1000_0000;
  localparam logic [8:0] S_BAD     = 9'b1_0000_0000;

  localparam logic [CW-1:0] ITER_MAX = CW'(MAX_ITER);

  logic [8:0]    state;
  logic [8:0]    state_nxt;
  logic [W-1:0]  x_r, y_r, z_r, a_r, b_r;
  logic [CW-1:0] iter_r;
  logic          timeout_r;
  logic          onehot_ok_q;
  logic          onehot_err_r;
  logic [W-1:0]  cmp_a, cmp_b;
  logic          lt;
  logic          launch;

  // Shared comparator: operand selection is the only per-state difference.
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    case (state)
      S_CMP_XY: begin cmp_a = x_r; cmp_b = y_r; end
      S_CMP_AB: begin cmp_a = a_r; cmp_b = b_r; end
      S_CMP_XZ: begin cmp_a = x_r; cmp_b = z_r; end
      default:  begin cmp_a = '0;  cmp_b = '0;  end
    endcase
  end

  assign lt     = cmp_a < cmp_b;
  assign launch = start & ((state == S_IDLE) | (state == S_DONE_OK) | (state == S_ABORT));

  // Non-one-hot encodings fall to the default arm and simply hold.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE_OK, S_ABORT: if (start) state_nxt = S_CMP_XY;
      S_CMP_XY: state_nxt = lt ? S_LOAD_A : S_ABORT;
      S_LOAD_A: state_nxt = S_CMP_AB;
      S_CMP_AB: begin
        if (lt) state_nxt = (iter_r == ITER_MAX) ? S_ABORT : S_UPD;
        else    state_nxt = (iter_r == '0) ? S_ABORT : S_CMP_XZ;
      end
      S_UPD:    state_nxt = S_CMP_AB;
      S_CMP_XZ: state_nxt = lt ? S_DONE_OK : S_BAD;
      default:  state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      x_r          <= '0;
      y_r          <= '0;
      z_r          <= '0;
      a_r          <= '0;
      b_r          <= '0;
      iter_r       <= '0;
      timeout_r    <= 1'b0;
      onehot_ok_q  <= 1'b1;
      onehot_err_r <= 1'b0;
    end else begin
      onehot_ok_q <= $onehot(state);
      if (!onehot_ok_q) begin
        onehot_err_r <= 1'b1;
      end else begin
        state <= state_nxt;
        if (launch) begin
          x_r       <= x_in;
          y_r       <= y_in;
          z_r       <= z_in;
          b_r       <= b_in;
          a_r       <= '0;
          iter_r    <= '0;
          timeout_r <= 1'b0;
        end
        if (state == S_LOAD_A) a_r <= y_r;
        if (state == S_UPD) begin
          z_r    <= b_r;
          a_r    <= a_r + W'(1);
          iter_r <= iter_r + CW'(1);
        end
        if ((state == S_CMP_AB) && lt && (iter_r == ITER_MAX)) timeout_r <= 1'b1;
      end
    end
  end

  assign busy       = |(state & (S_CMP_XY | S_LOAD_A | S_CMP_AB | S_UPD | S_CMP_XZ));
  assign done       = |(state & (S_DONE_OK | S_ABORT));
  assign ok         = state[6];
  assign bad        = state[8];
  assign timeout    = timeout_r;
  assign onehot_err = onehot_err_r;
  assign a_out      = a_r;
  assign z_out      = z_r;
  assign iter_cnt   = iter_r;
  assign prop       = ~bad;

endmodule

// File: tb/tb_ball_loop_sequencer.sv
// Bench for ball_loop_sequencer: vector table, randomized runs against an arithmetic
// model of the loop outcome, and hand sequences for start-hold, reset and one-hot faults.
module tb_ball_loop_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, start4;
  logic [7:0] x_in, y_in, z_in, b_in;

  logic       busy, done, ok, timeout, d_bad, onehot_err, prop;
  logic [7:0] a_out, z_out, iter_cnt;
  logic       busy4, done4, ok4, timeout4, d_bad4, onehot_err4, prop4;
  logic [7:0] a_out4, z_out4, iter_cnt4;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ball_loop_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in), .z_in(z_in), .b_in(b_in),
    .busy(busy), .done(done), .ok(ok), .timeout(timeout), .bad(d_bad), .onehot_err(onehot_err),
    .a_out(a_out), .z_out(z_out), .iter_cnt(iter_cnt), .prop(prop)
  );

  ball_loop_sequencer #(.MAX_ITER(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .x_in(x_in), .y_in(y_in), .z_in(z_in), .b_in(b_in),
    .busy(busy4), .done(done4), .ok(ok4), .timeout(timeout4), .bad(d_bad4),
    .onehot_err(onehot_err4), .a_out(a_out4), .z_out(z_out4), .iter_cnt(iter_cnt4),
    .prop(prop4)
  );

  typedef struct {
    bit ok;
    bit to;
    int a;
    int z;
    int iter;
    int lat;
  } res_t;

  typedef struct {
    int   x, y, z, b;
    res_t exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outcome of one run from the loop rules: iterations needed = B-Y when Y<B.
  function automatic res_t model(input int x, input int y, input int z, input int b,
                                 input int max_iter);
    res_t r;
    int   n;
    r.ok = 0; r.to = 0; r.z = z; r.iter = 0; r.a = 0; r.lat = 1;
    if (!(x < y)) return r;
    n = (b > y) ? b - y : 0;
    if (n == 0) begin
      r.a = y; r.lat = 3;
    end else if (n > max_iter) begin
      r.to = 1; r.iter = max_iter; r.a = y + max_iter;
      r.z = (max_iter > 0) ? b : z;
      r.lat = 2 + 2 * max_iter + 1;
    end else begin
      r.ok = (x < b); r.iter = n; r.a = b; r.z = b; r.lat = 2 * n + 4;
    end
    return r;
  endfunction

  task automatic launch_and_measure(input int x, input int y, input int z, input int b,
                                    input bit use4, output int lat0, output int lat4);
    int busy_err;
    busy_err = 0;
    lat0 = -1;
    lat4 = use4 ? -1 : 0;
    @(negedge clk);
    x_in = 8'(x); y_in = 8'(y); z_in = 8'(z); b_in = 8'(b);
    start = 1'b1; start4 = use4;
    for (int k = 0; k < 700; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin start = 1'b0; start4 = 1'b0; end
      if (lat0 < 0) begin
        if (done) lat0 = k;
        else if (!busy) busy_err++;
      end
      if (use4 && lat4 < 0) begin
        if (done4) lat4 = k;
        else if (!busy4) busy_err++;
      end
      if (lat0 >= 0 && lat4 >= 0) break;
    end
    check("busy_during_run", busy_err, 0);
  endtask

  task automatic wait_done(input int k0, output int lat);
    lat = -1;
    for (int k = k0; k < 700; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; return; end
    end
  endtask

  task automatic check_res(input string tag, input bit is4, input res_t e, input int lat);
    if (!is4) begin
      check({tag, "_ok"}, ok, e.ok);
      check({tag, "_timeout"}, timeout, e.to);
      check({tag, "_a"}, a_out, e.a);
      check({tag, "_z"}, z_out, e.z);
      check({tag, "_iter"}, iter_cnt, e.iter);
      check({tag, "_prop"}, prop, 1);
    end else begin
      check({tag, "_ok4"}, ok4, e.ok);
      check({tag, "_timeout4"}, timeout4, e.to);
      check({tag, "_a4"}, a_out4, e.a);
      check({tag, "_z4"}, z_out4, e.z);
      check({tag, "_iter4"}, iter_cnt4, e.iter);
      check({tag, "_prop4"}, prop4, 1);
    end
    check({tag, "_latency"}, lat, e.lat);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_flags"}, {busy, done, ok, timeout, d_bad, onehot_err, prop}, 7'b0000001);
    check({tag, "_data"}, {a_out, z_out, iter_cnt}, 24'd0);
    check({tag, "_flags4"}, {busy4, done4, ok4, timeout4, d_bad4, onehot_err4, prop4},
          7'b0000001);
  endtask

  initial begin
    vec_t vecs[9];
    res_t e, e4;
    int   lat0, lat4, x, y, z, b;

    vecs[0] = '{x:3,   y:5,   z:0,   b:8,   exp:'{ok:1, to:0, a:8,   z:8,   iter:3,  lat:10}};
    vecs[1] = '{x:5,   y:5,   z:77,  b:9,   exp:'{ok:0, to:0, a:0,   z:77,  iter:0,  lat:1}};
    vecs[2] = '{x:1,   y:9,   z:42,  b:9,   exp:'{ok:0, to:0, a:9,   z:42,  iter:0,  lat:3}};
    vecs[3] = '{x:0,   y:1,   z:3,   b:2,   exp:'{ok:1, to:0, a:2,   z:2,   iter:1,  lat:6}};
    vecs[4] = '{x:200, y:201, z:0,   b:255, exp:'{ok:1, to:0, a:255, z:255, iter:54, lat:112}};
    vecs[5] = '{x:9,   y:3,   z:5,   b:100, exp:'{ok:0, to:0, a:0,   z:5,   iter:0,  lat:1}};
    vecs[6] = '{x:0,   y:255, z:1,   b:255, exp:'{ok:0, to:0, a:255, z:1,   iter:0,  lat:3}};
    vecs[7] = '{x:0,   y:0,   z:0,   b:0,   exp:'{ok:0, to:0, a:0,   z:0,   iter:0,  lat:1}};
    vecs[8] = '{x:0,   y:10,  z:4,   b:5,   exp:'{ok:0, to:0, a:10,  z:4,   iter:0,  lat:3}};

    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    x_in = '0; y_in = '0; z_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      launch_and_measure(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].b, 1'b0, lat0, lat4);
      check_res($sformatf("vec%0d", i), 1'b0, vecs[i].exp, lat0);
    end

    // Loop bound reached on the MAX_ITER=4 instance, then a new start clears timeout.
    launch_and_measure(0, 1, 9, 200, 1'b1, lat0, lat4);
    check_res("bound", 1'b1, '{ok:0, to:1, a:5, z:200, iter:4, lat:11}, lat4);
    wait_done(lat0 + 1, lat0);
    @(negedge clk);
    x_in = 8'd3; y_in = 8'd5; z_in = 8'd0; b_in = 8'd8; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("bound_restart_timeout4", timeout4, 0);
    check("bound_restart_busy4", busy4, 1);
    repeat (10) @(posedge clk);
    #1;
    check("bound_restart_ok4", ok4, 1);

    for (int t = 0; t < 40; t++) begin
      y = $urandom_range(0, 255);
      x = ($urandom_range(0, 3) != 0 && y > 0) ? $urandom_range(0, y - 1) : $urandom_range(0, 255);
      z = $urandom_range(0, 255);
      b = ($urandom_range(0, 1) != 0) ? y + $urandom_range(0, 12) : $urandom_range(0, 255);
      if (b > 255) b = 255;
      e  = model(x, y, z, b, 255);
      e4 = model(x, y, z, b, 4);
      launch_and_measure(x, y, z, b, 1'b1, lat0, lat4);
      check_res($sformatf("rnd%0d", t), 1'b0, e, lat0);
      check_res($sformatf("rnd%0d", t), 1'b1, e4, lat4);
    end

    // start held high: inputs changed mid-run must not be latched; relaunch from DONE_OK.
    @(negedge clk);
    x_in = 8'd3; y_in = 8'd5; z_in = 8'd0; b_in = 8'd8; start = 1'b1;
    @(posedge clk); #1;
    x_in = 8'd1; y_in = 8'd2; z_in = 8'd0; b_in = 8'd4;
    wait_done(1, lat0);
    check_res("hold", 1'b0, '{ok:1, to:0, a:8, z:8, iter:3, lat:10}, lat0);
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_relaunch_busy", busy, 1);
    check("hold_relaunch_done", done, 0);
    wait_done(1, lat0);
    check_res("relaunch", 1'b0, '{ok:1, to:0, a:4, z:4, iter:2, lat:8}, lat0);

    // Reset while in UPD (state after edge 3).
    @(negedge clk);
    x_in = 8'd0; y_in = 8'd1; z_in = 8'd7; b_in = 8'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("rst_in_upd");
    @(negedge clk);
    rst = 1'b0;

    // Two-hot state: registers must freeze and onehot_err must rise.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_force_data", {a_out, z_out, iter_cnt}, {8'd3, 8'd200, 8'd2});
    @(negedge clk);
    force dut.state = 9'b0_0001_1000;
    repeat (4) @(posedge clk);
    #1;
    check("frozen_data", {a_out, z_out, iter_cnt}, {8'd3, 8'd200, 8'd2});
    check("onehot_err", onehot_err, 1);
    repeat (3) @(posedge clk);
    #1;
    check("still_frozen", {a_out, z_out, iter_cnt, onehot_err}, {8'd3, 8'd200, 8'd2, 1'b1});
    @(negedge clk);
    release dut.state;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("rst_after_fault");
    @(negedge clk);
    rst = 1'b0;

    launch_and_measure(3, 5, 0, 8, 1'b0, lat0, lat4);
    check_res("post_fault", 1'b0, '{ok:1, to:0, a:8, z:8, iter:3, lat:10}, lat0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
